// File: rtl/div_seq_ctrl_if.sv
// Handshake/bus bundle between the EXE stage, the iterative divider and div_seq_ctrl.
interface div_seq_ctrl_if;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_mem_i;
    logic        div_done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_start;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_annul;
    logic        stall_div;
    logic        hilo_we;
    logic [63:0] hilo_o;
    logic        dbz_o;
    logic        timeout_o;

    // Pipeline/divider side: drives requests and divider results.
    modport master (
        output start_i, signed_i, a_i, b_i, flush_i, stall_mem_i,
        output div_done, quotient, remainder,
        input  div_start, div_sign, div_a, div_b, div_annul,
        input  stall_div, hilo_we, hilo_o, dbz_o, timeout_o
    );

    // Sequencer side.
    modport slave (
        input  start_i, signed_i, a_i, b_i, flush_i, stall_mem_i,
        input  div_done, quotient, remainder,
        output div_start, div_sign, div_a, div_b, div_annul,
        output stall_div, hilo_we, hilo_o, dbz_o, timeout_o
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for div/divu: latches operands, runs the iterative divider with a
// timeout, handles divide-by-zero, flushes and MEM stalls, and writes HI/LO once.
module div_seq_ctrl #(
    parameter logic [5:0] TIMEOUT = 6'd40
) (
    input logic          clk,
    input logic          rst,
    div_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StZero, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic [63:0] result_q, result_d;
    logic        dbz_q, dbz_d;
    logic        tmo_q, tmo_d;
    logic        annul;

    // Next-state, datapath capture and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        tmo_d    = tmo_q;
        annul    = 1'b0;

        bus.div_start = 1'b0;
        bus.div_sign  = 1'b0;
        bus.div_a     = '0;
        bus.div_b     = '0;
        bus.stall_div = 1'b0;
        bus.hilo_we   = 1'b0;
        bus.hilo_o    = '0;
        bus.dbz_o     = 1'b0;
        bus.timeout_o = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.flush_i) begin
                    bus.stall_div = 1'b1;
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    sign_d  = bus.signed_i;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = (bus.b_i == 32'h0) ? StZero : StRun;
                end
            end
            StRun: begin
                bus.stall_div = 1'b1;
                bus.div_start = !bus.div_done;
                bus.div_sign  = sign_q;
                bus.div_a     = a_q;
                bus.div_b     = b_q;
                cnt_d = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;
                // Flush beats a same-cycle div_done; div_done beats the timeout.
                if (bus.flush_i) begin
                    annul   = 1'b1;
                    state_d = StIdle;
                end else if (bus.div_done) begin
                    result_d = {bus.remainder, bus.quotient};
                    state_d  = StDone;
                end else if (cnt_q == TIMEOUT) begin
                    annul    = 1'b1;
                    result_d = '0;
                    tmo_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StZero: begin
                bus.stall_div = 1'b1;
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else begin
                    result_d = {a_q, 32'hFFFF_FFFF};
                    dbz_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                bus.hilo_o    = result_q;
                bus.dbz_o     = dbz_q;
                bus.timeout_o = tmo_q;
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else if (!bus.stall_mem_i) begin
                    bus.hilo_we = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // The divider shares rst, so a reset cycle never needs a cancel.
        bus.div_annul = annul & rst;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule
